// File: rtl/pipe_pkg.sv
// Shared types for the valid/ready skid pipeline stage.
package pipe_pkg;

  // Occupancy of the stage: nothing held, main entry only, or main plus skid entry.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/skid_entry.sv
// One storage entry of the skid stage: a LENGTH-bit register that loads on
// demand and clears asynchronously while reset is low.
module skid_entry #(
  parameter int LENGTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LENGTH-1:0] d,
  output logic [LENGTH-1:0] q
);

  // Hold the payload until told to load; reset wipes it immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a one-entry skid buffer. in_ready depends
// only on the state flops, so the consumer's ready never reaches the producer
// combinationally, and back-to-back transfers still run at one per cycle.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int LENGTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data
);

  skid_state_t       state;
  skid_state_t       state_next;
  logic              in_xfer;
  logic              out_xfer;
  logic              main_load;
  logic              skid_load;
  logic [LENGTH-1:0] main_d;
  logic [LENGTH-1:0] main_q;
  logic [LENGTH-1:0] skid_q;

  assign out_valid = (state != SKID_EMPTY);
  assign in_ready  = (state != SKID_FULL);
  assign out_data  = main_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // The main entry refills from the skid entry when draining FULL, otherwise
  // from the producer; a flush suppresses every load so squashed data never lands.
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_data;
    unique case (state)
      SKID_EMPTY: main_load = in_xfer;
      SKID_ONE: begin
        main_load = in_xfer & out_xfer;
        skid_load = in_xfer & ~out_xfer;
      end
      SKID_FULL: begin
        main_load = out_xfer;
        main_d    = skid_q;
      end
      default: ;
    endcase
    if (flush) begin
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // Occupancy tracking; flush always returns the stage to empty.
  always_comb begin
    state_next = state;
    unique case (state)
      SKID_EMPTY: if (in_xfer) state_next = SKID_ONE;
      SKID_ONE: begin
        if (in_xfer && !out_xfer)      state_next = SKID_FULL;
        else if (!in_xfer && out_xfer) state_next = SKID_EMPTY;
      end
      SKID_FULL: if (out_xfer) state_next = SKID_ONE;
      default: state_next = SKID_EMPTY;
    endcase
    if (flush) begin
      state_next = SKID_EMPTY;
    end
  end

  // State register, cleared asynchronously so held data is dropped at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SKID_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  skid_entry #(.LENGTH(LENGTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  skid_entry #(.LENGTH(LENGTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

  a_state_legal: assert property (@(posedge clk) disable iff (!reset)
    state inside {SKID_EMPTY, SKID_ONE, SKID_FULL});

  a_not_ready_full: assert property (@(posedge clk) disable iff (!reset)
    !in_ready |-> state == SKID_FULL);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomised checks of pipe_skid_stage against hand-computed
// values and an occupancy/queue reference model.
module tb_pipe_skid_stage;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;

  int test_count = 0;
  int fail_count = 0;

  pipe_skid_stage #(.LENGTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] d,
                               input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic ov, input logic ir,
                            input logic [4:0] od);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    checkOutput({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    if (ov) checkOutput({tag, ".out_data"}, 32'(out_data), 32'(od));
  endtask

  logic [4:0] model_q[$];
  logic       in_x;
  logic       out_x;
  logic       pending;

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 5'h00, 1'b0, 1'b0);
    #1;
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset.out_data",  32'(out_data),  32'd0);
    #11 reset = 1'b1;
    step();
    checkState("idle", 1'b0, 1'b1, 5'h00);

    // Streaming with the consumer always ready.
    applyStimulus(1'b1, 5'h01, 1'b1, 1'b0); step();
    checkState("stream0", 1'b1, 1'b1, 5'h01);
    applyStimulus(1'b1, 5'h02, 1'b1, 1'b0); step();
    checkState("stream1", 1'b1, 1'b1, 5'h02);
    applyStimulus(1'b1, 5'h03, 1'b1, 1'b0); step();
    checkState("stream2", 1'b1, 1'b1, 5'h03);
    applyStimulus(1'b0, 5'h00, 1'b1, 1'b0); step();
    checkState("stream_drain", 1'b0, 1'b1, 5'h00);

    // Stall fills main then skid; the third word waits at the producer.
    applyStimulus(1'b1, 5'h0A, 1'b0, 1'b0); step();
    checkState("stall0", 1'b1, 1'b1, 5'h0A);
    applyStimulus(1'b1, 5'h0B, 1'b0, 1'b0); step();
    checkState("stall_full", 1'b1, 1'b0, 5'h0A);
    applyStimulus(1'b1, 5'h0C, 1'b0, 1'b0); step();
    checkState("stall_hold", 1'b1, 1'b0, 5'h0A);
    // FULL with an out transfer: in_ready stays low, 0C is not taken yet.
    applyStimulus(1'b1, 5'h0C, 1'b1, 1'b0);
    checkOutput("full_xfer.in_ready_low", 32'(in_ready), 32'd0);
    step();
    checkState("full_to_one", 1'b1, 1'b1, 5'h0B);
    step();
    checkState("stall_last", 1'b1, 1'b1, 5'h0C);
    applyStimulus(1'b0, 5'h00, 1'b1, 1'b0); step();
    checkState("stall_drain", 1'b0, 1'b1, 5'h00);

    // Flush while FULL with a new offer present: everything disappears.
    applyStimulus(1'b1, 5'h11, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 5'h12, 1'b0, 1'b0); step();
    checkState("pre_flush", 1'b1, 1'b0, 5'h11);
    applyStimulus(1'b1, 5'h1F, 1'b0, 1'b1); step();
    checkState("flush", 1'b0, 1'b1, 5'h00);
    applyStimulus(1'b0, 5'h00, 1'b1, 1'b0); step();
    checkState("post_flush0", 1'b0, 1'b1, 5'h00);
    step();
    checkState("post_flush1", 1'b0, 1'b1, 5'h00);
    applyStimulus(1'b1, 5'h05, 1'b1, 1'b0); step();
    checkState("post_flush_new", 1'b1, 1'b1, 5'h05);
    applyStimulus(1'b0, 5'h00, 1'b1, 1'b0); step();
    checkState("post_flush_drain", 1'b0, 1'b1, 5'h00);

    // Asynchronous reset in the middle of FULL.
    applyStimulus(1'b1, 5'h03, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 5'h04, 1'b0, 1'b0); step();
    checkState("pre_reset_full", 1'b1, 1'b0, 5'h03);
    applyStimulus(1'b0, 5'h00, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("async_reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset.in_ready",  32'(in_ready),  32'd1);
    checkOutput("async_reset.out_data",  32'(out_data),  32'd0);
    #1 reset = 1'b1;
    step();
    checkState("after_reset", 1'b0, 1'b1, 5'h00);

    // Random traffic against a FIFO model, with occasional flushes.
    model_q.delete();
    pending = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checkOutput("rand.out_valid", 32'(out_valid), 32'(model_q.size() > 0));
      checkOutput("rand.in_ready",  32'(in_ready),  32'(model_q.size() < 2));
      if (model_q.size() > 0)
        checkOutput("rand.out_data", 32'(out_data), 32'(model_q[0]));
      if (!pending) begin
        in_valid = ($urandom_range(0, 99) < 60);
        in_data  = 5'($urandom_range(0, 31));
      end
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 2);
      in_x  = in_valid && (model_q.size() < 2);
      out_x = out_ready && (model_q.size() > 0);
      step();
      if (flush) begin
        model_q.delete();
        pending = 1'b0;
      end else begin
        if (out_x) void'(model_q.pop_front());
        if (in_x) model_q.push_back(in_data);
        pending = in_valid && !in_x;
      end
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
